// File: rtl/control_unit_mc_if.sv
// control_unit_mc_if: fetch/datapath-facing bundle of the multi-cycle control unit.
interface control_unit_mc_if #(
  parameter int INSTR_W = 18,
  parameter int LANES   = 4,
  parameter int TAP_W   = 4
);
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic               stall;
  logic               reg_write;
  logic               mem_write;
  logic               mem_to_reg;
  logic [1:0]         imm_src;
  logic [1:0]         alu_src;
  logic [1:0]         reg_src;
  logic [2:0]         alu_control;
  logic [LANES-1:0]   lane_en;
  logic [TAP_W-1:0]   tap_idx;
  logic               acc_clear;
  logic               ctrl_valid;
  logic               illegal;
  modport master (
    output instr, instr_valid, stall,
    input  instr_ready, reg_write, mem_write, mem_to_reg, imm_src, alu_src, reg_src,
           alu_control, lane_en, tap_idx, acc_clear, ctrl_valid, illegal
  );
  modport slave (
    input  instr, instr_valid, stall,
    output instr_ready, reg_write, mem_write, mem_to_reg, imm_src, alu_src, reg_src,
           alu_control, lane_en, tap_idx, acc_clear, ctrl_valid, illegal
  );
endinterface

// File: rtl/control_unit_mc.sv
// control_unit_mc: lane-aware multi-cycle decoder sequencing MUL and CONV micro-ops.
module control_unit_mc #(
  parameter int INSTR_W     = 18,
  parameter int LANES       = 4,
  parameter int MUL_LAT     = 3,
  parameter int KERNEL_TAPS = 9,
  parameter int TAP_W       = $clog2(KERNEL_TAPS)
) (
  input logic clk,
  input logic rst_n,
  control_unit_mc_if.slave bus
);
  localparam int MAXC = MUL_LAT > KERNEL_TAPS ? MUL_LAT : KERNEL_TAPS;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, MUL_RUN, CONV_RUN} state_t;
  typedef struct packed {
    logic             reg_write;
    logic             mem_write;
    logic             mem_to_reg;
    logic [1:0]       imm_src;
    logic [1:0]       alu_src;
    logic [1:0]       reg_src;
    logic [2:0]       alu_control;
    logic [LANES-1:0] lane_en;
    logic [TAP_W-1:0] tap_idx;
    logic             acc_clear;
    logic             ctrl_valid;
    logic             illegal;
  } ctrl_t;
  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  ctrl_t            q, d;
  logic [3:0]       op;
  logic             imm_f;
  logic [LANES-1:0] mask;
  logic [LANES-1:0] lanes;
  logic             last;
  logic             ready;
  logic             accept;
  logic             unused_bits;
  assign op          = bus.instr[3:0];
  assign imm_f       = bus.instr[4];
  assign mask        = bus.instr[INSTR_W-1 -: LANES];
  assign lanes       = mask == '0 ? '1 : mask;
  assign unused_bits = ^bus.instr[INSTR_W-LANES-1:5];
  // Ready may overlap the final cycle of a running op so ops chain without a bubble.
  assign last   = state == ISSUE
                | (state == MUL_RUN  && cnt == CW'(MUL_LAT - 1))
                | (state == CONV_RUN && cnt == CW'(KERNEL_TAPS - 1));
  assign ready  = rst_n & ~bus.stall & (state == IDLE | last);
  assign accept = bus.instr_valid & ready;
  always_comb begin
    state_n = IDLE;
    cnt_n   = '0;
    d       = '0;
    if (accept) begin
      d.lane_en    = lanes;
      d.ctrl_valid = 1'b1;
      state_n      = ISSUE;
      case (op)
        4'd0: begin
          d.alu_src     = {1'b0, imm_f};
          d.alu_control = 3'b100;
          d.reg_write   = 1'b1;
        end
        4'd1: begin
          d.alu_src   = {1'b0, imm_f};
          d.reg_write = 1'b1;
        end
        4'd2: begin
          d.alu_src     = {1'b0, imm_f};
          d.alu_control = 3'b001;
          d.reg_write   = 1'b1;
        end
        4'd3: begin
          d.alu_src     = {1'b0, imm_f};
          d.alu_control = 3'b010;
          d.reg_write   = MUL_LAT == 1;
          state_n       = MUL_LAT == 1 ? ISSUE : MUL_RUN;
        end
        4'd4: begin
          d.alu_src     = 2'b10;
          d.imm_src     = 2'b10;
          d.alu_control = 3'b011;
          d.acc_clear   = 1'b1;
          state_n       = CONV_RUN;
        end
        4'd5: begin
          d.alu_src    = 2'b01;
          d.imm_src    = 2'b01;
          d.reg_write  = 1'b1;
          d.mem_to_reg = 1'b1;
        end
        4'd6: begin
          d.alu_src   = 2'b01;
          d.imm_src   = 2'b01;
          d.mem_write = 1'b1;
          d.reg_src   = 2'b10;
        end
        4'd7: ;
        default: begin
          d         = '0;
          d.illegal = 1'b1;
          state_n   = IDLE;
        end
      endcase
    end else if (state == MUL_RUN && !last) begin
      d           = q;
      cnt_n       = cnt + CW'(1);
      state_n     = MUL_RUN;
      d.reg_write = cnt_n == CW'(MUL_LAT - 1);
    end else if (state == CONV_RUN && !last) begin
      d           = q;
      cnt_n       = cnt + CW'(1);
      state_n     = CONV_RUN;
      d.tap_idx   = TAP_W'(cnt_n);
      d.acc_clear = 1'b0;
      d.reg_write = cnt_n == CW'(KERNEL_TAPS - 1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      q     <= '0;
    end else if (!bus.stall) begin
      state <= state_n;
      cnt   <= cnt_n;
      q     <= d;
    end
  end
  assign bus.instr_ready = ready;
  assign bus.reg_write   = q.reg_write;
  assign bus.mem_write   = q.mem_write;
  assign bus.mem_to_reg  = q.mem_to_reg;
  assign bus.imm_src     = q.imm_src;
  assign bus.alu_src     = q.alu_src;
  assign bus.reg_src     = q.reg_src;
  assign bus.alu_control = q.alu_control;
  assign bus.lane_en     = q.lane_en;
  assign bus.tap_idx     = q.tap_idx;
  assign bus.acc_clear   = q.acc_clear;
  assign bus.ctrl_valid  = q.ctrl_valid;
  assign bus.illegal     = q.illegal;
endmodule

// File: tb/tb_control_unit_mc.sv
// tb_control_unit_mc: directed checks of decode, MUL/CONV sequencing, stall, illegal and reset abort.
module tb_control_unit_mc;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  control_unit_mc_if #(.INSTR_W(18), .LANES(4), .TAP_W(4)) bus ();
  control_unit_mc #(.INSTR_W(18), .LANES(4), .MUL_LAT(3), .KERNEL_TAPS(9), .TAP_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  function automatic logic [17:0] mk(input logic [3:0] mask, input logic i, input logic [3:0] op);
    return {mask, 1'b0, 8'h5a, i, op};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    bus.instr = '0;
    bus.instr_valid = 1'b0;
    bus.stall = 1'b0;
    repeat (2) tick();
    chk("rst_ctrl_valid", 32'(bus.ctrl_valid), 0);
    chk("rst_ready", 32'(bus.instr_ready), 0);
    chk("rst_lane_en", 32'(bus.lane_en), 0);
    chk("rst_reg_write", 32'(bus.reg_write), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", 32'(bus.instr_ready), 1);
    chk("idle_ctrl_valid", 32'(bus.ctrl_valid), 0);
    chk("idle_alu", 32'(bus.alu_control), 0);
    // ADD, LDR, STR back to back
    bus.instr = mk(4'b0000, 1'b1, 4'd1);
    bus.instr_valid = 1'b1;
    tick();
    bus.instr = mk(4'b0000, 1'b0, 4'd5);
    chk("add_alu", 32'(bus.alu_control), 0);
    chk("add_alu_src", 32'(bus.alu_src), 1);
    chk("add_reg_write", 32'(bus.reg_write), 1);
    chk("add_mem_write", 32'(bus.mem_write), 0);
    chk("add_mem_to_reg", 32'(bus.mem_to_reg), 0);
    chk("add_reg_src", 32'(bus.reg_src), 0);
    chk("add_lane_en", 32'(bus.lane_en), 4'hf);
    chk("add_ctrl_valid", 32'(bus.ctrl_valid), 1);
    chk("add_ready", 32'(bus.instr_ready), 1);
    tick();
    bus.instr = mk(4'b0000, 1'b0, 4'd6);
    chk("ldr_alu", 32'(bus.alu_control), 0);
    chk("ldr_alu_src", 32'(bus.alu_src), 1);
    chk("ldr_imm_src", 32'(bus.imm_src), 1);
    chk("ldr_reg_write", 32'(bus.reg_write), 1);
    chk("ldr_mem_write", 32'(bus.mem_write), 0);
    chk("ldr_mem_to_reg", 32'(bus.mem_to_reg), 1);
    chk("ldr_reg_src", 32'(bus.reg_src), 0);
    tick();
    bus.instr_valid = 1'b0;
    chk("str_alu", 32'(bus.alu_control), 0);
    chk("str_alu_src", 32'(bus.alu_src), 1);
    chk("str_reg_write", 32'(bus.reg_write), 0);
    chk("str_mem_write", 32'(bus.mem_write), 1);
    chk("str_mem_to_reg", 32'(bus.mem_to_reg), 0);
    chk("str_reg_src", 32'(bus.reg_src), 2);
    chk("str_lane_en", 32'(bus.lane_en), 4'hf);
    tick();
    chk("post_str_ctrl_valid", 32'(bus.ctrl_valid), 0);
    chk("post_str_mem_write", 32'(bus.mem_write), 0);
    // MUL, mask 0101, three cycles
    bus.instr = mk(4'b0101, 1'b0, 4'd3);
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("mul%0d_ctrl_valid", c), 32'(bus.ctrl_valid), 1);
      chk($sformatf("mul%0d_alu", c), 32'(bus.alu_control), 3'b010);
      chk($sformatf("mul%0d_alu_src", c), 32'(bus.alu_src), 0);
      chk($sformatf("mul%0d_lane_en", c), 32'(bus.lane_en), 4'b0101);
      chk($sformatf("mul%0d_reg_write", c), 32'(bus.reg_write), c == 3 ? 1 : 0);
      chk($sformatf("mul%0d_ready", c), 32'(bus.instr_ready), c == 3 ? 1 : 0);
      tick();
    end
    chk("post_mul_ctrl_valid", 32'(bus.ctrl_valid), 0);
    chk("post_mul_reg_write", 32'(bus.reg_write), 0);
    // CONV, 9 taps, stall for two cycles at tap 4
    bus.instr = mk(4'b0000, 1'b0, 4'd4);
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      chk($sformatf("conv%0d_tap", k), 32'(bus.tap_idx), k);
      chk($sformatf("conv%0d_acc_clear", k), 32'(bus.acc_clear), k == 0 ? 1 : 0);
      chk($sformatf("conv%0d_reg_write", k), 32'(bus.reg_write), k == 8 ? 1 : 0);
      chk($sformatf("conv%0d_alu", k), 32'(bus.alu_control), 3'b011);
      chk($sformatf("conv%0d_alu_src", k), 32'(bus.alu_src), 2);
      chk($sformatf("conv%0d_imm_src", k), 32'(bus.imm_src), 2);
      chk($sformatf("conv%0d_ready", k), 32'(bus.instr_ready), k == 8 ? 1 : 0);
      chk($sformatf("conv%0d_lane_en", k), 32'(bus.lane_en), 4'hf);
      if (k == 4) begin
        bus.stall = 1'b1;
        for (int s = 0; s < 2; s++) begin
          tick();
          chk($sformatf("stall%0d_tap", s), 32'(bus.tap_idx), 4);
          chk($sformatf("stall%0d_ready", s), 32'(bus.instr_ready), 0);
          chk($sformatf("stall%0d_ctrl_valid", s), 32'(bus.ctrl_valid), 1);
          chk($sformatf("stall%0d_reg_write", s), 32'(bus.reg_write), 0);
        end
        bus.stall = 1'b0;
      end
      tick();
    end
    chk("post_conv_ctrl_valid", 32'(bus.ctrl_valid), 0);
    chk("post_conv_tap", 32'(bus.tap_idx), 0);
    // Illegal opcode
    bus.instr = mk(4'b0011, 1'b1, 4'hc);
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    chk("ill_pulse", 32'(bus.illegal), 1);
    chk("ill_ctrl_valid", 32'(bus.ctrl_valid), 0);
    chk("ill_reg_write", 32'(bus.reg_write), 0);
    chk("ill_lane_en", 32'(bus.lane_en), 0);
    chk("ill_ready", 32'(bus.instr_ready), 1);
    tick();
    chk("ill_pulse_end", 32'(bus.illegal), 0);
    // CONV aborted by reset at tap 3
    bus.instr = mk(4'b1000, 1'b0, 4'd4);
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    repeat (3) tick();
    chk("abort_tap_before", 32'(bus.tap_idx), 3);
    chk("abort_lane_before", 32'(bus.lane_en), 4'b1000);
    rst_n = 1'b0;
    #1;
    chk("abort_ctrl_valid", 32'(bus.ctrl_valid), 0);
    chk("abort_tap", 32'(bus.tap_idx), 0);
    chk("abort_alu", 32'(bus.alu_control), 0);
    chk("abort_alu_src", 32'(bus.alu_src), 0);
    chk("abort_lane_en", 32'(bus.lane_en), 0);
    chk("abort_ready", 32'(bus.instr_ready), 0);
    for (int r = 0; r < 3; r++) begin
      tick();
      chk($sformatf("abort_hold%0d_reg_write", r), 32'(bus.reg_write), 0);
    end
    rst_n = 1'b1;
    for (int r = 0; r < 8; r++) begin
      tick();
      chk($sformatf("after_abort%0d_reg_write", r), 32'(bus.reg_write), 0);
      chk($sformatf("after_abort%0d_ctrl_valid", r), 32'(bus.ctrl_valid), 0);
    end
    chk("after_abort_ready", 32'(bus.instr_ready), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
